decodificador_cuadratura: RTL

Parametrised quadrature-encoder decoder: synchronises and debounces the A/B channels, tracks the Gray-code phase, and produces count pulses at runtime-selectable resolution (x1/x2/x4). It also keeps a wrapping signed position register, reports direction, and flags illegal transitions. It sits between the encoder input pins and the position/UI logic, and replaces the fixed single-resolution encoder FSM.

---
 rtl/cuadratura_pkg.sv | 47 ++++
 rtl/decodificador_cuadratura_if.sv | 36 +++
 rtl/filtro_antirrebote.sv | 56 +++++
 rtl/decodificador_cuadratura.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/cuadratura_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cuadratura_pkg
// Description : Shared constants and helpers for the quadrature decoder.
//               Holds the resolution-mode codes, the Gray-code phase values
//               (forward order S1->S2->S3->S4->S1), the forward-successor
//               helper and the mode-to-threshold mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package cuadratura_pkg;

    localparam logic [1:0] MODO_X1 = 2'b00;
    localparam logic [1:0] MODO_X2 = 2'b01;
    localparam logic [1:0] MODO_X4 = 2'b10;

    // Phase encoding is {a,b}.
    localparam logic [1:0] S1 = 2'b00;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] S3 = 2'b11;
    localparam logic [1:0] S4 = 2'b01;

    // Quarter-steps needed for one count; the unused code 11 behaves as x4.
    function automatic logic signed [3:0] umbral(input logic [1:0] modo);
        logic signed [3:0] n;
        case (modo)
            MODO_X1: n = 4'sd4;
            MODO_X2: n = 4'sd2;
            MODO_X4: n = 4'sd1;
            default: n = 4'sd1;
        endcase
        return n;
    endfunction

    // Phase that follows 'fase' when the encoder turns forward.
    function automatic logic [1:0] sig_adelante(input logic [1:0] fase);
        logic [1:0] s;
        case (fase)
            S1:      s = S2;
            S2:      s = S3;
            S3:      s = S4;
            default: s = S1;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decodificador_cuadratura_if.sv
`default_nettype none
// ============================================================================
// Module      : decodificador_cuadratura_if
// Description : Pin/position bundle of the quadrature decoder.
//               slave  : the decoder (takes a, b, modo, cargar, valor_carga,
//                        borrar_error; drives sumar, restar, posicion,
//                        direccion, error)
//               master : the surrounding logic (the opposite directions)
// Revision    : 1.0 - initial release
// ============================================================================
interface decodificador_cuadratura_if #(
    parameter int ANCHO = 16
);
    logic             a;
    logic             b;
    logic [1:0]       modo;
    logic             cargar;
    logic [ANCHO-1:0] valor_carga;
    logic             borrar_error;
    logic             sumar;
    logic             restar;
    logic [ANCHO-1:0] posicion;
    logic             direccion;
    logic             error;

    modport slave (
        input  a, b, modo, cargar, valor_carga, borrar_error,
        output sumar, restar, posicion, direccion, error
    );

    modport master (
        output a, b, modo, cargar, valor_carga, borrar_error,
        input  sumar, restar, posicion, direccion, error
    );
endinterface
`default_nettype wire

// File: rtl/filtro_antirrebote.sv
`default_nettype none
// ============================================================================
// Module      : filtro_antirrebote
// Description : One encoder channel: 2-FF synchroniser followed by a debounce
//               filter. The output level follows the synchronised input only
//               after it has differed for FILTRO consecutive cycles; any
//               agreement in between restarts the count.
//   clk, rst   : clock, synchronous active-high reset
//   i_entrada  : raw asynchronous channel
//   o_nivel    : filtered level
// Revision    : 1.0 - initial release
// ============================================================================
module filtro_antirrebote #(
    parameter int FILTRO = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_entrada,
    output logic      o_nivel
);

    localparam int ANCHO_CNT = (FILTRO > 1) ? $clog2(FILTRO) : 1;
    localparam logic [ANCHO_CNT-1:0] c_limite = ANCHO_CNT'(FILTRO - 1);

    logic                 r_sinc1;
    logic                 r_sinc2;
    logic                 r_nivel;
    logic [ANCHO_CNT-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sinc1 <= 1'b0;
            r_sinc2 <= 1'b0;
            r_nivel <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sinc1 <= i_entrada;
            r_sinc2 <= r_sinc1;
            if (r_sinc2 != r_nivel) begin
                // This cycle is the FILTRO-th consecutive disagreement.
                if (r_cnt == c_limite) begin
                    r_nivel <= r_sinc2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + ANCHO_CNT'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_nivel = r_nivel;

endmodule
`default_nettype wire

// File: rtl/decodificador_cuadratura.sv
`default_nettype none
// ============================================================================
// Module      : decodificador_cuadratura
// Description : Quadrature-encoder decoder with x1/x2/x4 resolution, wrapping
//               signed position, direction and sticky illegal-step flag.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of decodificador_cuadratura_if (pins, mode, load,
//              error clear in; count pulses, position, direction, error out)
// Revision    : 1.0 - initial release
// ============================================================================
module decodificador_cuadratura
    import cuadratura_pkg::*;
#(
    parameter int ANCHO  = 16,
    parameter int FILTRO = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    decodificador_cuadratura_if.slave bus
);

    // After reset the filtered pair is adopted silently. If the pins sit at
    // 00 no filtered change ever appears, so a window slightly longer than
    // the filter latency also marks the phase as known.
    localparam int ANCHO_ARR = $clog2(FILTRO + 3);
    localparam logic [ANCHO_ARR-1:0] c_arranque = ANCHO_ARR'(FILTRO + 2);

    logic                 w_a;
    logic                 w_b;
    logic [1:0]           w_par;
    logic [1:0]           w_dif;
    logic                 w_cambio;
    logic                 w_ilegal;
    logic                 w_valido;
    logic                 w_adelante;
    logic signed [3:0]    w_paso;
    logic signed [3:0]    w_base;
    logic signed [3:0]    w_suma;
    logic signed [3:0]    w_umbral;
    logic                 w_llega_pos;
    logic                 w_llega_neg;

    logic [1:0]           r_fase;
    logic                 r_inicializado;
    logic [ANCHO_ARR-1:0] r_arranque;
    logic signed [2:0]    r_acc;
    logic [1:0]           r_modo_ant;
    logic                 r_sumar;
    logic                 r_restar;
    logic [ANCHO-1:0]     r_posicion;
    logic                 r_direccion;
    logic                 r_error;

    filtro_antirrebote #(.FILTRO(FILTRO)) u_filtro_a (
        .clk       (clk),
        .rst       (rst),
        .i_entrada (bus.a),
        .o_nivel   (w_a)
    );

    filtro_antirrebote #(.FILTRO(FILTRO)) u_filtro_b (
        .clk       (clk),
        .rst       (rst),
        .i_entrada (bus.b),
        .o_nivel   (w_b)
    );

    always_comb begin
        w_par      = {w_a, w_b};
        w_dif      = w_par ^ r_fase;
        w_cambio   = |w_dif;
        w_ilegal   = r_inicializado && (w_dif == 2'b11);
        w_valido   = r_inicializado && ((w_dif == 2'b01) || (w_dif == 2'b10));
        w_adelante = (w_par == sig_adelante(r_fase));
        w_paso     = w_valido ? (w_adelante ? 4'sd1 : -4'sd1) : 4'sd0;
        // A mode change discards partial progress; the sum is evaluated
        // one bit wider than the stored accumulator so +4 is representable.
        w_base     = (bus.modo != r_modo_ant) ? 4'sd0 : $signed({r_acc[2], r_acc});
        w_suma     = w_base + w_paso;
        w_umbral   = umbral(bus.modo);
        w_llega_pos = w_valido && (w_suma == w_umbral);
        w_llega_neg = w_valido && (w_suma == -w_umbral);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fase         <= S1;
            r_inicializado <= 1'b0;
            r_arranque     <= '0;
            r_acc          <= '0;
            r_modo_ant     <= MODO_X1;
            r_sumar        <= 1'b0;
            r_restar       <= 1'b0;
            r_posicion     <= '0;
            r_direccion    <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_modo_ant <= bus.modo;
            r_sumar    <= w_llega_pos && !bus.cargar;
            r_restar   <= w_llega_neg && !bus.cargar;

            if (!r_inicializado) begin
                if (w_cambio) begin
                    r_fase         <= w_par;
                    r_inicializado <= 1'b1;
                end else if (r_arranque == c_arranque) begin
                    r_inicializado <= 1'b1;
                end else begin
                    r_arranque <= r_arranque + ANCHO_ARR'(1);
                end
            end else if (w_cambio) begin
                r_fase <= w_par;
            end

            if (w_valido) begin
                r_direccion <= w_adelante;
            end

            if (bus.cargar || w_ilegal || w_llega_pos || w_llega_neg) begin
                r_acc <= '0;
            end else begin
                r_acc <= w_suma[2:0];
            end

            if (bus.cargar) begin
                r_posicion <= bus.valor_carga;
            end else if (w_llega_pos) begin
                r_posicion <= r_posicion + ANCHO'(1);
            end else if (w_llega_neg) begin
                r_posicion <= r_posicion - ANCHO'(1);
            end

            // Set wins over a same-cycle clear.
            if (w_ilegal) begin
                r_error <= 1'b1;
            end else if (bus.borrar_error) begin
                r_error <= 1'b0;
            end
        end
    end

    assign bus.sumar     = r_sumar;
    assign bus.restar    = r_restar;
    assign bus.posicion  = r_posicion;
    assign bus.direccion = r_direccion;
    assign bus.error     = r_error;

endmodule
`default_nettype wire
